gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised memory-mapped GPIO peripheral that succeeds the fixed 32-bit `gpio_in`/`gpio_out` pair on `CtlUnit`. It provides:
- a per-bit direction register;
- atomic set, clear and toggle of outputs;
- metastability synchronisation of inputs;
- per-bit rising/falling edge detection with a maskable, level-sensitive interrupt.

It sits on the core's simple single-cycle peripheral bus beside other memory-mapped I/O, and drives pads or the top-level `gpio_*` ports.

## Interface
Parameters
- `WIDTH`, 32: number of GPIO bits, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

Ports
- `sys_clk`  in  1  single clock.
- `sys_rst`  in  1  reset; synchronous and active-high.
- `bus_req`  in  1  transaction strobe; one transaction per cycle where high.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  6  byte address; bits [5:2] select register, [1:0] ignored.
- `bus_wdata`  in  32  write data.
- `bus_rdata`  out  32  read data, valid while `bus_ack` is high.
- `bus_ack`  out  1  completion pulse, exactly one cycle after each `bus_req`.
- `gpio_in`  in  WIDTH  asynchronous pad inputs.
- `gpio_out`  out  WIDTH  output register.
- `gpio_oe`  out  WIDTH  output enable, equal to DIR (1 = drive).
- `irq`  out  1  level interrupt; equals `|(STATUS & IE)`.

## Operation
Register map (word offsets; all registers WIDTH bits, zero-extended on read, `wdata[31:WIDTH]` ignored):
- 0x00 IN: RO; synchronised input value.
- 0x04 OUT: RW; writing replaces the output register.
- 0x08 OUT_SET: WO, reads 0; `OUT |= wdata`.
- 0x0C OUT_CLR: WO, reads 0; `OUT &= ~wdata`.
- 0x10 OUT_TGL: WO, reads 0; `OUT ^= wdata`.
- 0x14 DIR: RW.
- 0x18 IE: RW; interrupt enable.
- 0x1C RISE: RW; rising-edge detect enable.
- 0x20 FALL: RW; falling-edge detect enable.
- 0x24 STATUS: RW1C; latched edge events.
- 0x28..0x3C: unmapped. Writes are ignored, reads return 0, and `bus_ack` is still issued.

Input sampling and edge detection:
- Input path: `gpio_in` → SYNC_STAGES flops → `in_sync` → one further flop `in_prev`.
- Per-bit event: `(RISE & in_sync & ~in_prev) | (FALL & ~in_sync & in_prev)`.
- Events set STATUS bits in the same cycle. STATUS is sticky until cleared.
- Detection is independent of DIR, so a pin driven as an output still reports its own edges.

Warm-up:
- After reset, a counter suppresses event detection for SYNC_STAGES+1 cycles while the pipeline fills.
- This prevents a spurious edge on pins that are already high at reset.

Simultaneous events:
- A STATUS W1C on a bit in the same cycle as a new event on that bit: the event wins and the bit stays 1.
- Writes to RISE/FALL take effect from the following cycle.
- Clearing IE deasserts `irq` without changing STATUS.

## Timing
- Bus transaction: request at edge n is registered, and `bus_ack`/`bus_rdata` are valid during cycle n+1.
- Register writes update at edge n, so a read issued at n+1 returns the new value.
- Back-to-back requests are legal; an ack is issued every cycle.
- Outputs: `gpio_out` and `gpio_oe` change at the edge that accepts the write, i.e. visible 1 cycle after the request.
- Input latency:
  - A change on `gpio_in` before edge k appears in `in_sync` after edge k+SYNC_STAGES-1.
  - STATUS is set, and `irq` rises (if IE), at edge k+SYNC_STAGES.
  - A read of IN reflects the change once `in_sync` has updated.
- Reset values: OUT, DIR, IE, RISE, FALL, STATUS, all synchroniser stages, `in_prev`, `bus_rdata`, `bus_ack` and `irq` are 0; the warm-up counter is loaded with SYNC_STAGES+1.
- Reset mid-transaction: the pending ack is dropped and no write is committed.
- Glitches shorter than one clock may be missed; no debouncing is performed.

## Structure
- Package `gpio_pkg` holds:
  - register offset localparams (`GPIO_IN` … `GPIO_STATUS`);
  - register-index width;
  - helper constant `GPIO_MAX_WIDTH = 32`.
- Sub-module `gpio_sync` holds the WIDTH-wide, SYNC_STAGES-deep synchroniser chain with synchronous reset. It is instantiated once; `in_prev` stays in `gpio_bank`.
- The register file, bus decode, edge logic and warm-up counter live in `gpio_bank`.

## Test plan
- **Reset/defaults:** assert `sys_rst` for 2 cycles with `gpio_in = 32'h12345678`.
  - All outputs are 0 and STATUS = 0 after warm-up.
  - A read of IN returns `32'h12345678` with `bus_ack` one cycle after `bus_req`.
- **Output ops:**
  - Write OUT = `32'hF0F0_0000`, then SET `32'h0000_000F`, CLR `32'h8000_0000`, TGL `32'h0000_00FF`.
  - `gpio_out` = `32'h70F0_00F0`, and a read of OUT matches.
  - A read of SET returns 0.
- **Edge IRQ:**
  - Set RISE = 1, IE = 1, then drive `gpio_in[0]` 0→1 before edge k.
  - STATUS[0] and `irq` go high at edge k+2 (SYNC_STAGES=2).
  - W1C of 1 clears both.
- **Collision:** issue W1C of STATUS[3] in the same cycle as a new falling edge on bit 3 (FALL[3] = 1) → STATUS[3] remains 1.
- **Width/unmapped:**
  - With WIDTH=8, write DIR = `32'hFFFF_FFFF` → reads `32'h0000_00FF`.
  - Write to 0x30 → no register changes; the read returns 0 and ack is still issued.
- **Back-to-back and mid-reset:**
  - Five consecutive `bus_req` cycles produce five consecutive acks.
  - Asserting `sys_rst` in the cycle after a write request suppresses the ack and leaves the register at 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register map, index width and the
// decoded bus request used inside the block.
package gpio_pkg;

    localparam int GPIO_MAX_WIDTH = 32;
    localparam int REG_IDX_W      = 4;

    // Word index of each register, i.e. byte address [5:2].
    localparam logic [REG_IDX_W-1:0] GPIO_IN      = 4'h0;
    localparam logic [REG_IDX_W-1:0] GPIO_OUT     = 4'h1;
    localparam logic [REG_IDX_W-1:0] GPIO_OUT_SET = 4'h2;
    localparam logic [REG_IDX_W-1:0] GPIO_OUT_CLR = 4'h3;
    localparam logic [REG_IDX_W-1:0] GPIO_OUT_TGL = 4'h4;
    localparam logic [REG_IDX_W-1:0] GPIO_DIR     = 4'h5;
    localparam logic [REG_IDX_W-1:0] GPIO_IE      = 4'h6;
    localparam logic [REG_IDX_W-1:0] GPIO_RISE    = 4'h7;
    localparam logic [REG_IDX_W-1:0] GPIO_FALL    = 4'h8;
    localparam logic [REG_IDX_W-1:0] GPIO_STATUS  = 4'h9;

    typedef struct packed {
        logic                      we;
        logic [REG_IDX_W-1:0]      idx;
        logic [GPIO_MAX_WIDTH-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/gpio_sync.sv
// WIDTH-wide input synchroniser, SYNC_STAGES flops deep, synchronous reset.
module gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            chain <= '0;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: direction, atomic output ops, synchronised inputs
// and per-bit edge detection feeding a maskable level interrupt.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             bus_req,
    input  logic             bus_we,
    input  logic [5:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ack,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam int WARM_W = $clog2(SYNC_STAGES + 2);

    bus_req_t req;
    logic [WIDTH-1:0] wd;
    logic             wr_en;
    logic [WIDTH-1:0] w1c;

    logic [WIDTH-1:0] out_q, dir_q, ie_q, rise_q, fall_q, status_q;
    logic [WIDTH-1:0] in_sync, in_prev, event_v;
    logic [WARM_W-1:0] warm_q;

    logic                      ack_q;
    logic [GPIO_MAX_WIDTH-1:0] rdata_q, rd_val;
    logic                      unused_bits;

    assign req = '{we: bus_we, idx: bus_addr[5:2], wdata: bus_wdata};
    assign wd    = req.wdata[WIDTH-1:0];
    assign wr_en = bus_req & req.we;
    assign w1c   = (wr_en && req.idx == GPIO_STATUS) ? wd : '0;
    assign unused_bits = ^{bus_addr[1:0], req.wdata};

    gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       (gpio_in),
        .q       (in_sync)
    );

    // Edges are ignored until the synchroniser and in_prev hold real samples.
    always_comb begin
        event_v = '0;
        if (warm_q == '0) begin
            event_v = (rise_q & in_sync & ~in_prev) | (fall_q & ~in_sync & in_prev);
        end
    end

    always_comb begin
        rd_val = '0;
        case (req.idx)
            GPIO_IN:     rd_val[WIDTH-1:0] = in_sync;
            GPIO_OUT:    rd_val[WIDTH-1:0] = out_q;
            GPIO_DIR:    rd_val[WIDTH-1:0] = dir_q;
            GPIO_IE:     rd_val[WIDTH-1:0] = ie_q;
            GPIO_RISE:   rd_val[WIDTH-1:0] = rise_q;
            GPIO_FALL:   rd_val[WIDTH-1:0] = fall_q;
            GPIO_STATUS: rd_val[WIDTH-1:0] = status_q;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_q    <= '0;
            dir_q    <= '0;
            ie_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            in_prev  <= '0;
            warm_q   <= WARM_W'(SYNC_STAGES + 1);
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            in_prev <= in_sync;
            if (warm_q != '0) warm_q <= warm_q - WARM_W'(1);

            if (wr_en) begin
                case (req.idx)
                    GPIO_OUT:     out_q  <= wd;
                    GPIO_OUT_SET: out_q  <= out_q | wd;
                    GPIO_OUT_CLR: out_q  <= out_q & ~wd;
                    GPIO_OUT_TGL: out_q  <= out_q ^ wd;
                    GPIO_DIR:     dir_q  <= wd;
                    GPIO_IE:      ie_q   <= wd;
                    GPIO_RISE:    rise_q <= wd;
                    GPIO_FALL:    fall_q <= wd;
                    default: ;
                endcase
            end

            // A fresh event outranks a same-cycle W1C on that bit.
            status_q <= (status_q & ~w1c) | event_v;

            ack_q   <= bus_req;
            rdata_q <= (bus_req && !req.we) ? rd_val : '0;
        end
    end

    // Reset arriving while an ack is pending drops that ack immediately.
    assign bus_ack   = ack_q & ~sys_rst;
    assign bus_rdata = rdata_q;
    assign gpio_out  = out_q;
    assign gpio_oe   = dir_q;
    assign irq       = |(status_q & ie_q);

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank: a 32-bit and an 8-bit instance share the bus
// and pins; a behavioural model predicts reads, pins and irq for both.
module tb_gpio_bank;

    localparam int SS = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic [5:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] gpio_in = 32'h1234_5678;

    logic [31:0] rdata32, out32, oe32;
    logic        ack32, irq32;
    logic [31:0] rdata8;
    logic [7:0]  out8, oe8;
    logic        ack8, irq8;

    always #5 sys_clk = ~sys_clk;

    gpio_bank #(.WIDTH(32), .SYNC_STAGES(SS)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata32), .bus_ack(ack32),
        .gpio_in(gpio_in), .gpio_out(out32), .gpio_oe(oe32), .irq(irq32)
    );

    gpio_bank #(.WIDTH(8), .SYNC_STAGES(SS)) dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata8), .bus_ack(ack8),
        .gpio_in(gpio_in[7:0]), .gpio_out(out8), .gpio_oe(oe8), .irq(irq8)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endfunction

    // Reference model: 32-bit register state; every register is a bitwise map,
    // so the 8-bit instance is predicted by masking to the low byte.
    typedef struct {
        bit          rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hist[$];  // gpio_in as sampled at each edge, newest first
    logic [31:0] m_out = '0, m_dir = '0, m_ie = '0, m_rise = '0, m_fall = '0, m_status = '0;
    int          m_edges = 0;

    always @(posedge sys_clk) begin
        logic [31:0] isync, iprev, ev, rv, w, clr;
        exp_t e;
        if (sys_rst) begin
            m_out = '0; m_dir = '0; m_ie = '0; m_rise = '0; m_fall = '0; m_status = '0;
            hist.delete();
            for (int i = 0; i <= SS; i++) hist.push_back('0);
            m_edges = 0;
        end else begin
            isync = hist[SS-1];
            iprev = hist[SS];
            ev = (m_edges >= SS + 1) ? ((m_rise & isync & ~iprev) | (m_fall & ~isync & iprev)) : '0;
            clr = '0;
            if (bus_req) begin
                w = bus_wdata;
                case (bus_addr[5:2])
                    4'd0:    rv = isync;
                    4'd1:    rv = m_out;
                    4'd5:    rv = m_dir;
                    4'd6:    rv = m_ie;
                    4'd7:    rv = m_rise;
                    4'd8:    rv = m_fall;
                    4'd9:    rv = m_status;
                    default: rv = '0;
                endcase
                e.rd = !bus_we;
                e.data = rv;
                sb.push_back(e);
                if (bus_we) begin
                    case (bus_addr[5:2])
                        4'd1: m_out = w;
                        4'd2: m_out = m_out | w;
                        4'd3: m_out = m_out & ~w;
                        4'd4: m_out = m_out ^ w;
                        4'd5: m_dir = w;
                        4'd6: m_ie = w;
                        4'd7: m_rise = w;
                        4'd8: m_fall = w;
                        4'd9: clr = w;
                        default: ;
                    endcase
                end
            end
            m_status = (m_status & ~clr) | ev;
            hist.push_front(gpio_in);
            void'(hist.pop_back());
            m_edges++;
        end
    end

    logic [31:0] last_rd = '0, last_rd8 = '0;
    int          ack_cnt = 0;

    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst) begin
            chk("ack_during_reset", {31'b0, ack32}, 32'd0);
            chk("ack8_during_reset", {31'b0, ack8}, 32'd0);
            sb.delete();
        end else begin
            chk("ack", {31'b0, ack32}, {31'b0, sb.size() != 0});
            chk("ack8", {31'b0, ack8}, {31'b0, sb.size() != 0});
            if (ack32) ack_cnt++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.rd) begin
                    chk("rdata", rdata32, e.data);
                    chk("rdata8", rdata8, e.data & 32'h0000_00FF);
                    last_rd = rdata32;
                    last_rd8 = rdata8;
                end
            end
        end
        chk("gpio_out", out32, m_out);
        chk("gpio_oe", oe32, m_dir);
        chk("irq", {31'b0, irq32}, {31'b0, |(m_status & m_ie)});
        chk("gpio_out8", {24'b0, out8}, m_out & 32'hFF);
        chk("gpio_oe8", {24'b0, oe8}, m_dir & 32'hFF);
        chk("irq8", {31'b0, irq8}, {31'b0, |(m_status & m_ie & 32'hFF)});
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Presents one request for one cycle; leaves it asserted for back-to-back use.
    task automatic op(input bit we, input logic [5:0] addr, input logic [31:0] data);
        bus_req = 1'b1;
        bus_we = we;
        bus_addr = addr;
        bus_wdata = data;
        tick(1);
    endtask

    task automatic idle(input int n);
        bus_req = 1'b0;
        bus_we = 1'b0;
        tick(n);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        op(1'b1, addr, data);
        idle(1);
    endtask

    task automatic rd(input logic [5:0] addr);
        op(1'b0, addr, '0);
        idle(1);
    endtask

    int acks_before;

    initial begin
        // Reset with pins already high; an immediate RISE-all must not catch them.
        tick(2);
        sys_rst = 1'b0;
        chk("reset_gpio_out", out32, 32'd0);
        chk("reset_irq", {31'b0, irq32}, 32'd0);
        wr(6'h1C, 32'hFFFF_FFFF);
        idle(SS + 2);
        rd(6'h00);
        chk("in_after_reset", last_rd, 32'h1234_5678);
        rd(6'h24);
        chk("status_after_warmup", last_rd, 32'd0);
        wr(6'h1C, 32'd0);

        // Output ops, back-to-back.
        op(1'b1, 6'h04, 32'hF0F0_0000);
        op(1'b1, 6'h08, 32'h0000_000F);
        op(1'b1, 6'h0C, 32'h8000_0000);
        op(1'b1, 6'h10, 32'h0000_00FF);
        idle(1);
        chk("out_ops_pins", out32, 32'h70F0_00F0);
        rd(6'h04);
        chk("out_ops_read", last_rd, 32'h70F0_00F0);
        rd(6'h08);
        chk("set_reads_zero", last_rd, 32'd0);

        // Rising edge on bit 0 reaches STATUS/irq SS edges after its sampling edge.
        wr(6'h1C, 32'h1);
        wr(6'h18, 32'h1);
        idle(2);
        gpio_in[0] = 1'b1;
        tick(1);
        tick(1);
        chk("irq_not_yet", {31'b0, irq32}, 32'd0);
        tick(1);
        chk("irq_rises", {31'b0, irq32}, 32'd1);
        rd(6'h24);
        chk("status0_set", last_rd, 32'h1);
        wr(6'h24, 32'h1);
        chk("irq_cleared", {31'b0, irq32}, 32'd0);
        rd(6'h24);
        chk("status0_cleared", last_rd, 32'd0);

        // Clearing IE drops irq but keeps STATUS.
        gpio_in[0] = 1'b0;
        idle(3);
        gpio_in[0] = 1'b1;
        idle(4);
        chk("irq_again", {31'b0, irq32}, 32'd1);
        wr(6'h18, 32'd0);
        chk("irq_masked", {31'b0, irq32}, 32'd0);
        rd(6'h24);
        chk("status_kept", last_rd & 32'h1, 32'h1);

        // W1C colliding with a new falling edge on bit 3.
        wr(6'h20, 32'h8);
        wr(6'h24, 32'hFFFF_FFFF);
        idle(2);
        gpio_in[3] = 1'b0;
        idle(2);
        op(1'b1, 6'h24, 32'h8);
        idle(1);
        rd(6'h24);
        chk("collision_status3", last_rd & 32'h8, 32'h8);

        // Width truncation and unmapped space.
        wr(6'h14, 32'hFFFF_FFFF);
        rd(6'h14);
        chk("dir8_read", last_rd8, 32'h0000_00FF);
        chk("dir32_read", last_rd, 32'hFFFF_FFFF);
        wr(6'h30, 32'hFFFF_FFFF);
        rd(6'h30);
        chk("unmapped_read", last_rd, 32'd0);

        // Five back-to-back requests, five acks.
        acks_before = ack_cnt;
        op(1'b0, 6'h00, '0);
        op(1'b0, 6'h04, '0);
        op(1'b0, 6'h14, '0);
        op(1'b0, 6'h24, '0);
        op(1'b0, 6'h28, '0);
        idle(1);
        chk("b2b_acks", ack_cnt - acks_before, 32'd5);

        // Reset in the cycle after a write: no ack, register ends at 0.
        acks_before = ack_cnt;
        op(1'b1, 6'h04, 32'hDEAD_BEEF);
        bus_req = 1'b0;
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        chk("midreset_no_ack", ack_cnt - acks_before, 32'd0);
        chk("midreset_out", out32, 32'd0);
        idle(SS + 2);
        rd(6'h04);
        chk("midreset_out_read", last_rd, 32'd0);

        // Randomised traffic and pin activity.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ $urandom();
            if ($urandom_range(0, 9) < 7) begin
                bus_req = 1'b1;
                bus_we = $urandom_range(0, 1) == 1;
                bus_addr = 6'($urandom_range(0, 63));
                bus_wdata = $urandom();
            end else begin
                bus_req = 1'b0;
            end
            tick(1);
        end
        idle(2);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
